// File: rtl/jtag_host_pkg.sv
// Shared encodings, FSM states and TMS sequences for the JTAG host sequencer.
package jtag_host_pkg;

   typedef enum logic [1:0] {
      OP_RESET    = 2'b00,
      OP_SHIFT_IR = 2'b01,
      OP_SHIFT_DR = 2'b10,
      OP_IDLE     = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFIX,
      ST_SHIFT,
      ST_SUFFIX,
      ST_RESP
   } state_e;

   // TMS sequences, bit 0 is driven on the first TCK rising edge.
   localparam logic [7:0] TMS_RESET     = 8'b0001_1111;
   localparam logic [7:0] TMS_PRE_IR    = 8'b0000_0011;
   localparam logic [7:0] TMS_PRE_DR    = 8'b0000_0001;
   localparam logic [7:0] TMS_SUFFIX    = 8'b0000_0001;
   localparam int         RESET_LEN     = 6;
   localparam int         PRE_IR_LEN    = 4;
   localparam int         PRE_DR_LEN    = 3;
   localparam int         SUFFIX_LEN    = 2;

   function automatic logic [2:0] prefix_last(op_e op);
      case (op)
         OP_RESET:    return 3'(RESET_LEN - 1);
         OP_SHIFT_IR: return 3'(PRE_IR_LEN - 1);
         OP_SHIFT_DR: return 3'(PRE_DR_LEN - 1);
         default:     return 3'd0;
      endcase
   endfunction

   function automatic logic prefix_tms(op_e op, logic [2:0] step);
      case (op)
         OP_RESET:    return TMS_RESET[step];
         OP_SHIFT_IR: return TMS_PRE_IR[step];
         OP_SHIFT_DR: return TMS_PRE_DR[step];
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles tck every TCK_DIV clk while enabled, with one-cycle
// strobes marking the clk edge on which tck rises or falls.
module jtag_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic park,
   output logic tck,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int              CNT_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tck_q, tck_d;
   logic             term;

   assign term     = (cnt_q == CNT_LAST);
   assign rise_stb = en && term && !tck_q;
   assign fall_stb = en && term && tck_q;
   assign tck      = tck_q;

   // While parked the low phase still completes (rise_stb fires) but tck stays low.
   always_comb begin
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (!en) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (term) begin
         cnt_d = '0;
         if (!(rise_stb && park)) tck_d = !tck_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

endmodule

// File: rtl/jtag_host_sequencer.sv
// Host-side JTAG sequencer: turns RESET / SHIFT_IR / SHIFT_DR / IDLE commands
// into TCK/TMS/TDI waveforms and returns captured TDO bits as a response.
module jtag_host_sequencer
   import jtag_host_pkg::*;
#(
   parameter int TCK_DIV = 2,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               rsp_err,
   output logic               tap_synced,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   input  logic               tdo
);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               tap_synced_q, tap_synced_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               park_q, park_d;
   logic               tck_en, rise_stb, fall_stb;

   // TMS/TDI for the step identified by (state, idx); applied on the falling toggle.
   function automatic logic drive_tms(state_e st, op_e op, logic [LEN_W-1:0] idx,
                                      logic [LEN_W-1:0] len);
      case (st)
         ST_PREFIX: return prefix_tms(op, idx[2:0]);
         ST_SHIFT:  return (op != OP_IDLE) && (idx == len - LEN_ONE);
         ST_SUFFIX: return TMS_SUFFIX[idx[2:0]];
         default:   return 1'b0;
      endcase
   endfunction

   function automatic logic drive_tdi(state_e st, op_e op, logic [LEN_W-1:0] idx,
                                      logic [MAX_LEN-1:0] data);
      logic [MAX_LEN-1:0] sh;
      sh = data >> idx;
      return (st == ST_SHIFT) && (op != OP_IDLE) && sh[0];
   endfunction

   assign tck_en     = (state_q == ST_PREFIX) || (state_q == ST_SHIFT) || (state_q == ST_SUFFIX);
   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign tap_synced = tap_synced_q;
   assign tms        = tms_q;
   assign tdi        = tdi_q;

   jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (tck_en),
      .park     (park_q),
      .tck      (tck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // NOTE: every _d takes its _q value first, so no path through this block infers a latch.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      len_d        = len_q;
      idx_d        = idx_q;
      data_d       = data_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      tap_synced_d = tap_synced_q;
      tms_d        = tms_q;
      tdi_d        = tdi_q;
      park_d       = park_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d       = op_e'(cmd_op);
               len_d      = cmd_len;
               data_d     = cmd_data;
               idx_d      = '0;
               park_d     = 1'b0;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               if (op_d != OP_RESET && (!tap_synced_q || cmd_len > LEN_MAX)) begin
                  rsp_err_d = 1'b1;
                  state_d   = ST_RESP;
               end else if (op_d != OP_RESET && cmd_len == '0) begin
                  state_d = ST_RESP;
               end else begin
                  // tck is low here, so the first step's TMS/TDI go out immediately.
                  state_d = (op_d == OP_IDLE) ? ST_SHIFT : ST_PREFIX;
                  tms_d   = drive_tms(state_d, op_d, '0, cmd_len);
                  tdi_d   = drive_tdi(state_d, op_d, '0, cmd_data);
               end
            end
         end

         ST_PREFIX, ST_SHIFT, ST_SUFFIX: begin
            if (rise_stb && park_q) begin
               state_d = ST_RESP;
               if (op_q == OP_RESET) tap_synced_d = 1'b1;
            end else if (rise_stb) begin
               case (state_q)
                  ST_PREFIX: begin
                     if (idx_q == LEN_W'(prefix_last(op_q))) begin
                        idx_d = '0;
                        if (op_q == OP_RESET) park_d = 1'b1;
                        else                  state_d = ST_SHIFT;
                     end else begin
                        idx_d = idx_q + LEN_ONE;
                     end
                  end
                  ST_SHIFT: begin
                     if (op_q != OP_IDLE) rsp_data_d = rsp_data_q | (MAX_LEN'(tdo) << idx_q);
                     if (idx_q == len_q - LEN_ONE) begin
                        idx_d = '0;
                        if (op_q == OP_IDLE) park_d = 1'b1;
                        else                 state_d = ST_SUFFIX;
                     end else begin
                        idx_d = idx_q + LEN_ONE;
                     end
                  end
                  default: begin
                     if (idx_q == LEN_W'(SUFFIX_LEN - 1)) park_d = 1'b1;
                     else                                 idx_d = idx_q + LEN_ONE;
                  end
               endcase
            end else if (fall_stb && !park_q) begin
               tms_d = drive_tms(state_q, op_q, idx_q, len_q);
               tdi_d = drive_tdi(state_q, op_q, idx_q, data_q);
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
               park_d  = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_RESET;
         len_q        <= '0;
         idx_q        <= '0;
         data_q       <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         tap_synced_q <= 1'b0;
         tms_q        <= 1'b1;
         tdi_q        <= 1'b0;
         park_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         tap_synced_q <= tap_synced_d;
         tms_q        <= tms_d;
         tdi_q        <= tdi_d;
         park_q       <= park_d;
      end
   end

endmodule

// File: doc/jtag_host_sequencer.md
Name: jtag_host_sequencer

Overview:
- Host-side JTAG driver sitting directly upstream of the on-chip TAP controller.
- Converts simple command transactions (TAP reset, shift IR, shift DR, idle clocks) into TCK/TMS/TDI waveforms.
- Captures TDO bits and returns them as a response word.
- Runs entirely in the system clock domain; TCK is a divided, registered output.

Parameters:
- TCK_DIV, 2: clk cycles per TCK half-period; legal values are ≥1.
- MAX_LEN, 16: maximum shift length in bits; also the width of the data/response words.
- LEN_W, 5: width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE.
- cmd_len  in  LEN_W  bit count (SHIFT) or TCK count (IDLE).
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  MAX_LEN  captured TDO bits, LSB first, right-aligned, upper bits zero.
- rsp_err  out  1  command rejected.
- tap_synced  out  1  TAP state known to be Run-Test/Idle.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to TAP.
- tdo  in  1  JTAG data from TAP.

Behaviour:
- Reset values (rst is synchronous): tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, tap_synced=0. Divider cleared; FSM in IDLE.
- Command handshake:
  - A command is accepted on a clk edge with cmd_valid & cmd_ready.
  - cmd_ready=0 from the accepting cycle until the response has been accepted (rsp_valid & rsp_ready).
  - At most one command is outstanding.
- Response handshake:
  - rsp_valid stays high, with rsp_data and rsp_err stable, until rsp_ready.
  - cmd_ready returns to 1 in the cycle after that handshake.
- TCK generation:
  - A divider counts 0..TCK_DIV-1; each terminal count toggles tck. A full TCK period is 2*TCK_DIV clk.
  - Falling toggle: tms and tdi are updated for the next bit.
  - Rising toggle: tdo is sampled (value present before the edge) and the bit/step counter advances.
  - tck is idle-low whenever no command is executing; the divider is held at 0 while idle.
- FSM states: IDLE, PREFIX, SHIFT, SUFFIX, RESP.
  - The TMS sequence per op is driven one value per TCK rising edge.
  - RESET: TMS 1,1,1,1,1,0 (6 edges). Sets tap_synced=1. rsp_data=0.
  - SHIFT_DR: prefix 1,0,0; then cmd_len bits with TMS=0, last bit TMS=1; suffix 1,0. Total 5+cmd_len rising edges.
  - SHIFT_IR: prefix 1,1,0,0; then len bits as above; suffix 1,0. Total 6+cmd_len rising edges.
  - IDLE: cmd_len edges with TMS=0, tdi=0.
  - During SHIFT, tdi = cmd_data[i] for bit i. The tdo sampled on the rising edge that carries bit i is stored in rsp_data[i].
  - tdi=0 outside the SHIFT state.
  - After the last rising edge, tck completes its low phase, then RESP asserts rsp_valid.
- Boundary conditions:
  - cmd_len=0 on SHIFT/IDLE: no TCK activity; rsp_valid in the next cycle, rsp_data=0, rsp_err=0.
  - cmd_len>MAX_LEN: no TCK activity; rsp_err=1.
  - SHIFT_IR, SHIFT_DR or IDLE while tap_synced=0: no TCK activity; rsp_err=1, rsp_data=0.
  - rst mid-command: waveform aborts immediately to reset values, no response is produced, and tap_synced=0. Software must issue RESET.
  - TCK_DIV=1: tck toggles every clk.

Decomposition:
- Package jtag_host_pkg:
  - op encodings (OP_RESET, OP_SHIFT_IR, OP_SHIFT_DR, OP_IDLE);
  - FSM state enum;
  - prefix/suffix TMS constants and their lengths.
- Sub-module jtag_tck_gen (TCK_DIV): divider producing tck plus single-cycle rise_stb/fall_stb strobes, with an enable input.

Test Plan:
- TCK_DIV=2, RESET → exactly 6 tck rising edges, each 4 clk apart; TMS 1,1,1,1,1,0; rsp_valid with rsp_data=0, rsp_err=0; tap_synced=1.
- After rst, SHIFT_DR len 8 → rsp_err=1, zero tck edges; cmd_ready=1 the cycle after rsp_ready.
- RESET, then SHIFT_DR len 8 with tdo tied 1 → 13 rising edges; rsp_data=16'h00FF; TMS on the last shift edge =1, followed by 1,0.
- Against the downstream TAP: RESET, SHIFT_IR len 2 data 2'b01 (8 edges), then SHIFT_DR len 8 data 0 → rsp_data=16'h00AA.
- SHIFT_DR len 17 → rsp_err=1, no tck activity. IDLE len 0 → rsp_valid next cycle, rsp_data=0.
- Assert rst at the 4th tck edge of SHIFT_DR len 8 → next cycle tck=0, tms=1, tdi=0; no rsp_valid; tap_synced=0; cmd_ready=1.
